// File: rtl/soc_eoc_arbiter.sv
// Round-robin arbiter that shares one soc/eoc converter among N requesters,
// serving each one with a 4-phase req/ack handshake.
module soc_eoc_arbiter #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    ack,
    output logic [SELW-1:0] sel,
    output logic            soc,
    input  logic            eoc,
    input  logic [W-1:0]    x,
    output logic [W-1:0]    data,
    output logic            busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] CONV  = 3'd3;
    localparam logic [2:0] ACK   = 3'd4;

    localparam logic [SELW-1:0] LAST_RST = SELW'(N - 1);
    localparam logic [N-1:0]    ONE_HOT0 = N'(1);

    logic [2:0]      state;
    logic [SELW-1:0] last;
    logic [SELW-1:0] pick;

    // Scan from last+N down to last+1 so the closest requester after last wins;
    // last itself (offset N) only wins when nobody else is asking.
    function automatic logic [SELW-1:0] rr_pick(input logic [N-1:0]    r,
                                                input logic [SELW-1:0] from);
        logic [SELW-1:0] idx;
        logic [SELW-1:0] cand;
        int              pos;
        idx = from;
        for (int k = N; k >= 1; k--) begin
            pos = int'(from) + k;
            if (pos >= N) pos = pos - N;
            cand = pos[SELW-1:0];
            if (r[cand]) idx = cand;
        end
        return idx;
    endfunction

    always_comb begin
        pick = rr_pick(req, last);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= LAST_RST;
            sel   <= '0;
            soc   <= 1'b0;
            ack   <= '0;
            data  <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        sel   <= pick;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                // sel has had a full cycle to settle; wait for an idle converter
                SETUP: begin
                    if (eoc) begin
                        soc   <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (!eoc) begin
                        soc   <= 1'b0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    if (eoc) begin
                        data  <= x;
                        ack   <= ONE_HOT0 << sel;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (!req[sel]) begin
                        ack   <= '0;
                        busy  <= 1'b0;
                        last  <= sel;
                        state <= IDLE;
                    end
                end
                default: begin
                    soc   <= 1'b0;
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_eoc_arbiter.sv
// Bench for soc_eoc_arbiter: converter model, round-robin reference model,
// scoreboard monitor, directed scenarios and randomized requester agents.
`timescale 1ns/1ps
module tb_soc_eoc_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int SELW = 2;
    localparam int RAND_CYCLES = 10000;
    localparam int WT_ACK = 0, WT_SOC1 = 1, WT_SOC0 = 2, WT_BUSY = 3, WT_IDLE = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    ack;
    logic [SELW-1:0] sel;
    logic            soc;
    logic            busy;
    logic            eoc;
    logic            eoc_c;
    logic            force_busy;
    logic [W-1:0]    x;
    logic [W-1:0]    data;

    assign eoc = eoc_c & ~force_busy;

    soc_eoc_arbiter #(.N(N), .W(W), .SELW(SELW)) dut (
        .clock(clock), .reset(reset), .req(req), .ack(ack), .sel(sel),
        .soc(soc), .eoc(eoc), .x(x), .data(data), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Converter model: one conversion per accepted soc, result = base[channel].
    logic [W-1:0] base [N];
    int  conv_c = 1;
    int  conv_d = 3;
    bit  rand_cd = 1'b0;
    int  starts = 0;
    int  done_id = 0;

    initial begin
        int c, d, id;
        eoc_c = 1'b1;
        x = '0;
        forever begin
            @(negedge clock);
            if (soc && eoc_c && !reset) begin
                starts++;
                id = starts;
                c = rand_cd ? int'($urandom_range(1, 3)) : conv_c;
                d = rand_cd ? int'($urandom_range(1, 4)) : conv_d;
                repeat (c - 1) @(negedge clock);
                eoc_c = 1'b0;
                x = W'($urandom);
                repeat (d) @(negedge clock);
                x = base[sel];
                eoc_c = 1'b1;
                done_id = id;
            end
        end
    end

    // Reference model: 0 = free, 1 = serving (waiting for its conversion), 2 = acknowledged.
    typedef struct {
        int           chan;
        logic [W-1:0] val;
    } exp_t;
    exp_t sbq[$];
    int m_state = 0;
    int m_last = N - 1;
    int m_chan = 0;
    int m_target = 0;

    always @(posedge clock) begin
        bit found;
        int cand;
        exp_t e;
        if (reset) begin
            m_state = 0;
            m_last = N - 1;
            sbq.delete();
        end else begin
            case (m_state)
                0: if (req != '0) begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        cand = (m_last + k) % N;
                        if (!found && req[SELW'(cand)]) begin
                            found = 1'b1;
                            m_chan = cand;
                        end
                    end
                    e.chan = m_chan;
                    e.val = base[m_chan];
                    sbq.push_back(e);
                    m_target = starts + 1;
                    m_state = 1;
                end
                1: if (done_id >= m_target) m_state = 2;
                default: if (!req[SELW'(m_chan)]) begin
                    m_last = m_chan;
                    m_state = 0;
                end
            endcase
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each ack rise.
    logic [N-1:0] prev_ack = '0;
    int waitcnt [N];
    int soc_cycles = 0;

    always begin
        exp_t e;
        logic [N-1:0] exp_ack;
        @(posedge clock);
        #1;
        if (reset) begin
            prev_ack = '0;
            for (int j = 0; j < N; j++) waitcnt[j] = 0;
        end else begin
            if (soc) soc_cycles++;
            check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
            check("soc_ack_overlap", 32'(soc && (ack != '0)), 32'd0);
            if (ack != '0 && prev_ack == '0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got ack=%b expected no ack", ack);
                end else begin
                    e = sbq.pop_front();
                    exp_ack = '0;
                    exp_ack[SELW'(e.chan)] = 1'b1;
                    check("sb_ack", 32'(ack), 32'(exp_ack));
                    check("sb_sel", 32'(sel), 32'(e.chan));
                    check("sb_data", 32'(data), 32'(e.val));
                    check("sb_busy", 32'(busy), 32'd1);
                    for (int j = 0; j < N; j++) begin
                        if (j == e.chan) waitcnt[j] = 0;
                        else if (req[SELW'(j)]) begin
                            waitcnt[j]++;
                            check("fairness", 32'(waitcnt[j] <= N - 1), 32'd1);
                        end
                    end
                end
            end
            for (int j = 0; j < N; j++) if (!req[SELW'(j)]) waitcnt[j] = 0;
            prev_ack = ack;
        end
    end

    task automatic wait_for(input int what, input int bound, input string name);
        bit hit;
        hit = 1'b0;
        for (int t = 0; t < bound && !hit; t++) begin
            @(negedge clock);
            case (what)
                WT_ACK:  hit = (ack != '0);
                WT_SOC1: hit = soc;
                WT_SOC0: hit = !soc;
                WT_BUSY: hit = busy;
                default: hit = !busy;
            endcase
        end
        check(name, 32'(hit), 32'd1);
    endtask

    bit run_agents = 1'b0;

    task automatic agent(input int i);
        bit ok;
        while (run_agents) begin
            repeat ($urandom_range(0, 6)) @(negedge clock);
            if (run_agents && !ack[SELW'(i)]) begin
                req[SELW'(i)] = 1'b1;
                if ($urandom_range(0, 9) == 0) begin
                    repeat ($urandom_range(1, 8)) @(negedge clock);
                    req[SELW'(i)] = 1'b0;
                end else begin
                    ok = 1'b0;
                    for (int t = 0; t < 400 && !ok; t++) begin
                        @(negedge clock);
                        ok = ack[SELW'(i)];
                    end
                    check("agent_ack_timeout", 32'(ok), 32'd1);
                    repeat ($urandom_range(0, 2)) @(negedge clock);
                    req[SELW'(i)] = 1'b0;
                    ok = 1'b0;
                    for (int t = 0; t < 10 && !ok; t++) begin
                        @(negedge clock);
                        ok = !ack[SELW'(i)];
                    end
                    check("agent_ack_release", 32'(ok), 32'd1);
                end
            end
        end
    endtask

    initial begin
        int got;
        int exp_order [5];
        int prev_soc;
        exp_order = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        req = '0;
        force_busy = 1'b0;
        for (int i = 0; i < N; i++) base[i] = 8'h10 + W'(i);

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_soc", 32'(soc), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single request on channel 2
        base[2] = 8'hA5;
        prev_soc = soc_cycles;
        req = 4'b0100;
        wait_for(WT_ACK, 20, "single_ack_timeout");
        check("single_ack", 32'(ack), 32'b0100);
        check("single_sel", 32'(sel), 32'd2);
        check("single_data", 32'(data), 32'hA5);
        check("single_soc_pulse", 32'(soc_cycles - prev_soc), 32'd1);
        req = '0;
        @(negedge clock);
        check("single_rel_ack", 32'(ack), 32'd0);
        check("single_rel_busy", 32'(busy), 32'd0);

        // Round robin from a fresh reset: 0,1,2,3,0
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < N; i++) base[i] = 8'h10 + W'(i);
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_for(WT_ACK, 30, "rr_ack_timeout");
            got = -1;
            for (int j = 0; j < N; j++) if (ack[SELW'(j)]) got = j;
            check("rr_order", 32'(got), 32'(exp_order[t]));
            check("rr_data", 32'(data), 32'(8'h10 + exp_order[t]));
            if (t == 4) req = '0;
            else if (got >= 0) begin
                req[SELW'(got)] = 1'b0;
                @(negedge clock);
                req[SELW'(got)] = 1'b1;
            end
        end
        wait_for(WT_IDLE, 5, "rr_idle_timeout");

        // Busy converter holds off soc
        base[1] = 8'h3C;
        force_busy = 1'b1;
        req = 4'b0010;
        wait_for(WT_BUSY, 5, "busy_grant_timeout");
        check("busy_soc_hold", 32'(soc), 32'd0);
        repeat (5) begin
            @(negedge clock);
            check("busy_soc_hold", 32'(soc), 32'd0);
        end
        force_busy = 1'b0;
        @(negedge clock);
        check("busy_soc_rise", 32'(soc), 32'd1);
        wait_for(WT_ACK, 20, "busy_ack_timeout");
        check("busy_data", 32'(data), 32'h3C);
        req = '0;
        wait_for(WT_IDLE, 5, "busy_idle_timeout");

        // Abandon mid-conversion: one-cycle ack, then normal service of req[3]
        base[3] = 8'h5A;
        req = 4'b0010;
        wait_for(WT_SOC1, 10, "abandon_soc_timeout");
        repeat (2) @(negedge clock);
        req = '0;
        wait_for(WT_ACK, 20, "abandon_ack_timeout");
        check("abandon_ack", 32'(ack), 32'b0010);
        @(negedge clock);
        check("abandon_ack_1cyc", 32'(ack), 32'd0);
        check("abandon_busy", 32'(busy), 32'd0);
        req = 4'b1000;
        wait_for(WT_ACK, 20, "after_abandon_timeout");
        check("after_abandon_sel", 32'(sel), 32'd3);
        check("after_abandon_data", 32'(data), 32'h5A);
        req = '0;
        wait_for(WT_IDLE, 5, "after_abandon_idle");

        // Reset while converting
        req = 4'b0100;
        wait_for(WT_SOC1, 10, "rstconv_soc_timeout");
        wait_for(WT_SOC0, 10, "rstconv_conv_timeout");
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("rstconv_soc", 32'(soc), 32'd0);
        check("rstconv_ack", 32'(ack), 32'd0);
        check("rstconv_busy", 32'(busy), 32'd0);
        check("rstconv_sel", 32'(sel), 32'd0);
        req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        req = 4'b0001;
        wait_for(WT_ACK, 30, "rstconv_ack_timeout");
        check("rstconv_new_sel", 32'(sel), 32'd0);
        check("rstconv_new_data", 32'(data), 32'(base[0]));
        req = '0;
        wait_for(WT_IDLE, 5, "rstconv_idle");

        // Random requester streams
        for (int i = 0; i < N; i++) base[i] = W'($urandom);
        rand_cd = 1'b1;
        run_agents = 1'b1;
        for (int i = 0; i < N; i++) begin
            automatic int ii = i;
            fork
                agent(ii);
            join_none
        end
        repeat (RAND_CYCLES) @(negedge clock);
        run_agents = 1'b0;
        wait fork;
        req = '0;
        for (int t = 0; t < 100 && !(m_state == 0 && !busy); t++) @(negedge clock);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_ack", 32'(ack), 32'd0);
        check("drain_queue", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
